qnigma_tcp_tx_usr: RTL

// - User-side ingress stage directly upstream of the TCP transmission controller.
// - Buffers a ready/valid user byte stream in a small FIFO and drives the controller's dat/val/frc inputs.
// - Drains only while the controller's cts is high.
// - Generates frc (force packet) on a user end-of-message marker, and optionally after an idle timeout.

---
 rtl/qnigma_tcp_tx_usr_if.sv | 24 ++
 rtl/qnigma_tcp_tx_usr.sv | 112 +++++++++++
 2 files changed

// File: rtl/qnigma_tcp_tx_usr_if.sv
// Stream bundle between the user byte source, the TX ingress FIFO and the TCP transmission controller.
interface qnigma_tcp_tx_usr_if #(
   parameter int D = 4
);
   logic [7:0] usr_dat;
   logic       usr_val;
   logic       usr_lst;
   logic       usr_rdy;
   logic       cts;
   logic [7:0] dat;
   logic       val;
   logic       frc;
   logic [D:0] lvl;

   modport slave (
      input  usr_dat, usr_val, usr_lst, cts,
      output usr_rdy, dat, val, frc, lvl
   );

   modport master (
      output usr_dat, usr_val, usr_lst, cts,
      input  usr_rdy, dat, val, frc, lvl
   );
endinterface

// File: rtl/qnigma_tcp_tx_usr.sv
// User TX ingress: FWFT byte FIFO feeding the TCP controller, with force-packet on end-of-message.
// Optional idle-timeout force-packet enabled by macro QNIGMA_TCP_TX_USR_IDLE_FRC_EN.
module qnigma_tcp_tx_usr #(
   parameter int D        = 4,
   parameter int IDLE_TMO = 1000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   qnigma_tcp_tx_usr_if.slave      bus
);
   localparam int unsigned DEPTH = 2 ** D;

   logic [8:0]   mem_q [DEPTH];
   logic [D-1:0] wr_ptr_q, wr_ptr_d;
   logic [D-1:0] rd_ptr_q, rd_ptr_d;
   logic [D:0]   cnt_q, cnt_d;
   logic         frc_q, frc_d;
   logic         pending_q, pending_d;
   logic [8:0]   head;
   logic         push;
   logic         pop;
   logic         tmo;

   assign head        = mem_q[rd_ptr_q];
   assign bus.usr_rdy = (cnt_q != (D+1)'(DEPTH));
   assign bus.val     = (cnt_q != '0) && bus.cts;
   assign bus.dat     = (cnt_q != '0) ? head[7:0] : 8'h00;
   assign bus.lvl     = cnt_q;
   // A flush landing on a scheduled pulse kills it immediately.
   assign bus.frc     = frc_q && !flush;

   assign push = bus.usr_val && bus.usr_rdy;
   assign pop  = bus.val;

   // NOTE: storage carries no reset; pointers and count alone define which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {bus.usr_lst, bus.usr_dat};
      end
   end

`ifdef QNIGMA_TCP_TX_USR_IDLE_FRC_EN
   logic [15:0] idle_q, idle_d;

   // Fires on the cycle the counter steps onto IDLE_TMO-1, so frc lands IDLE_TMO cycles after the last pop.
   assign tmo = pending_q && !frc_q &&
                (({1'b0, idle_q} + 17'd1) >= 17'(IDLE_TMO - 1));

   always_comb begin
      idle_d = idle_q + 16'd1;
      if (flush || pop || frc_q || !pending_q || tmo) begin
         idle_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_d;
      end
   end
`else
   // Timeout compiled out; IDLE_TMO is inert in this build.
   assign tmo = (IDLE_TMO < 0);
`endif

   // NOTE: every next-state signal takes its hold value first so no path can infer a latch.
   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      pending_d = pending_q;
      frc_d     = 1'b0;
      if (flush) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         cnt_d     = '0;
         pending_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + D'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + D'(1);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + (D+1)'(1);
            2'b01:   cnt_d = cnt_q - (D+1)'(1);
            default: cnt_d = cnt_q;
         endcase
         // Data popped in the same cycle as a pulse belongs to the next packet.
         if (pop)        pending_d = 1'b1;
         else if (frc_q) pending_d = 1'b0;
         frc_d = (pop && head[8]) || tmo;
      end
   end

   // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         frc_q     <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         cnt_q     <= cnt_d;
         frc_q     <= frc_d;
         pending_q <= pending_d;
      end
   end
endmodule
